nn_node_loader: RTL

- Upstream feeder for the nn_node 4-4-2 fully-connected stage.
- Accepts a single 16-bit word stream over a valid/ready handshake and assembles the 24 weights (persistent) and the 4-element input vector (per inference).
- Drives nn_node's in0..in3 and weight inputs, then strobes in_ready long enough for both of nn_node's register stages to capture the vector.

---
 rtl/nn_pkg.sv | 41 ++++
 rtl/nn_weight_bank.sv | 38 +++
 rtl/nn_node_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and w_flat slot indices for the nn_node loader.
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int N_W    = 24;
    localparam int N_X    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_LOAD = 2'd1,
        X_LOAD = 2'd2,
        FIRE   = 2'd3
    } state_t;

    // Slot k of w_flat occupies bits [16k+15:16k].
    localparam int W04_IDX = 0;
    localparam int W05_IDX = 1;
    localparam int W06_IDX = 2;
    localparam int W07_IDX = 3;
    localparam int W14_IDX = 4;
    localparam int W15_IDX = 5;
    localparam int W16_IDX = 6;
    localparam int W17_IDX = 7;
    localparam int W24_IDX = 8;
    localparam int W25_IDX = 9;
    localparam int W26_IDX = 10;
    localparam int W27_IDX = 11;
    localparam int W34_IDX = 12;
    localparam int W35_IDX = 13;
    localparam int W36_IDX = 14;
    localparam int W37_IDX = 15;
    localparam int W48_IDX = 16;
    localparam int W58_IDX = 17;
    localparam int W49_IDX = 18;
    localparam int W59_IDX = 19;
    localparam int W68_IDX = 20;
    localparam int W69_IDX = 21;
    localparam int W78_IDX = 22;
    localparam int W79_IDX = 23;

endpackage

// File: rtl/nn_weight_bank.sv
// 24x16 weight register file: indexed write, flattened read, owns weights_valid.
module nn_weight_bank
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [4:0]              i_wr_idx,
    input  logic [DATA_W-1:0]       i_wr_data,
    output logic [N_W*DATA_W-1:0]   o_w_flat,
    output logic                    o_weights_valid
);

    logic [DATA_W-1:0] r_mem [N_W];
    logic              r_valid;

    // NOTE: the bank is reset because w_flat drives nn_node directly and must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_W; k++) r_mem[k] <= '0;
            r_valid <= 1'b0;
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
            // Slot 0 starts a new set, so the old set is no longer complete.
            if (i_wr_idx == 5'd0)
                r_valid <= 1'b0;
            else if (i_wr_idx == 5'(N_W - 1))
                r_valid <= 1'b1;
        end
    end

    for (genvar k = 0; k < N_W; k++) begin : g_flat
        assign o_w_flat[k*DATA_W +: DATA_W] = r_mem[k];
    end

    assign o_weights_valid = r_valid;

endmodule

// File: rtl/nn_node_loader.sv
// Stream-to-nn_node feeder: assembles weight and input-vector frames and strobes in_ready.
module nn_node_loader
    import nn_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_is_weight,
    output logic [DATA_W-1:0]       in0,
    output logic [DATA_W-1:0]       in1,
    output logic [DATA_W-1:0]       in2,
    output logic [DATA_W-1:0]       in3,
    output logic [N_W*DATA_W-1:0]   w_flat,
    output logic                    in_ready,
    output logic                    weights_valid,
    output logic                    err_no_weights,
    output logic [15:0]             vec_count
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_ready;
    logic [4:0]        r_widx;
    logic [1:0]        r_xidx;
    logic [DATA_W-1:0] r_x0, r_x1, r_x2;
    logic [DATA_W-1:0] r_in0, r_in1, r_in2, r_in3;
    logic              r_in_ready;
    logic [3:0]        r_hold;
    logic              r_err_no_weights;
    logic [15:0]       r_vec_count;

    logic              w_accept;
    logic              w_wr_en;
    logic [4:0]        w_wr_idx;
    logic              w_weights_valid;
    logic              w_last_x;

    assign w_accept = s_valid && r_ready;
    assign w_last_x = (r_xidx == 2'(N_X - 1));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_widx;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (s_is_weight) begin
                        w_next_state = W_LOAD;
                        w_wr_en      = 1'b1;
                        w_wr_idx     = 5'd0;
                    end else if (w_weights_valid) begin
                        w_next_state = X_LOAD;
                    end
                end
            end
            W_LOAD: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (r_widx == 5'(N_W - 1)) w_next_state = IDLE;
                end
            end
            X_LOAD: if (w_accept && w_last_x) w_next_state = FIRE;
            FIRE:   if (r_hold == 4'd0) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            r_state <= w_next_state;
        end
    end

    // s_ready is registered from the next state, so it is 0 in reset and throughout FIRE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready          <= 1'b0;
            r_widx           <= '0;
            r_xidx           <= '0;
            r_x0             <= '0;
            r_x1             <= '0;
            r_x2             <= '0;
            r_in0            <= '0;
            r_in1            <= '0;
            r_in2            <= '0;
            r_in3            <= '0;
            r_in_ready       <= 1'b0;
            r_hold           <= '0;
            r_err_no_weights <= 1'b0;
            r_vec_count      <= '0;
        end else begin
            r_ready <= (w_next_state != FIRE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (s_is_weight) begin
                            r_widx <= 5'd1;
                        end else if (w_weights_valid) begin
                            r_x0   <= s_data;
                            r_xidx <= 2'd1;
                        end else begin
                            r_err_no_weights <= 1'b1;
                        end
                    end
                end
                W_LOAD: begin
                    if (w_accept)
                        r_widx <= (r_widx == 5'(N_W - 1)) ? 5'd0 : r_widx + 5'd1;
                end
                X_LOAD: begin
                    if (w_accept) begin
                        if (w_last_x) begin
                            r_in0      <= r_x0;
                            r_in1      <= r_x1;
                            r_in2      <= r_x2;
                            r_in3      <= s_data;
                            r_in_ready <= 1'b1;
                            r_hold     <= 4'(HOLD_CYCLES - 1);
                            r_xidx     <= 2'd0;
                        end else begin
                            case (r_xidx)
                                2'd1:    r_x1 <= s_data;
                                2'd2:    r_x2 <= s_data;
                                default: r_x0 <= s_data;
                            endcase
                            r_xidx <= r_xidx + 2'd1;
                        end
                    end
                end
                FIRE: begin
                    if (r_hold == 4'd0) begin
                        r_in_ready  <= 1'b0;
                        r_vec_count <= r_vec_count + 16'd1;
                    end else begin
                        r_hold <= r_hold - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    nn_weight_bank u_weight_bank (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_wr_en         (w_wr_en),
        .i_wr_idx        (w_wr_idx),
        .i_wr_data       (s_data),
        .o_w_flat        (w_flat),
        .o_weights_valid (w_weights_valid)
    );

    assign s_ready        = r_ready;
    assign in0            = r_in0;
    assign in1            = r_in1;
    assign in2            = r_in2;
    assign in3            = r_in3;
    assign in_ready       = r_in_ready;
    assign weights_valid  = w_weights_valid;
    assign err_no_weights = r_err_no_weights;
    assign vec_count      = r_vec_count;

endmodule
